// File: rtl/snd_rom_arbiter.sv
// Round-robin arbiter sharing one 32-bit sound-ROM read port between N_REQ requesters,
// with one outstanding memory access and a one-word hit cache per requester.
module snd_rom_arbiter #(
   parameter int N_REQ   = 3,
   parameter int ADDR_W  = 18,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk_sys,
   input  logic                    nRESET,
   input  logic                    inhibit,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        rdy,
   output logic [31:0]             dout,
   output logic                    mem_req,
   output logic [ADDR_W-1:0]       mem_addr,
   input  logic                    mem_ack,
   input  logic [31:0]             mem_dout,
   output logic                    timeout_err
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HIT     = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_DELIVER = 3'd4
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [IDX_W-1:0]    rr_ptr_r;
   logic [IDX_W-1:0]    grant_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [CNT_W-1:0]    cnt_r;
   logic                inhibit_seen_r;
   logic [N_REQ-1:0]    cache_valid_r;
   logic [ADDR_W-1:0]   cache_tag_r  [N_REQ];
   logic [31:0]         cache_data_r [N_REQ];
   logic [N_REQ-1:0]    rdy_r;
   logic [31:0]         dout_r;
   logic                mem_req_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic                timeout_err_r;

   logic                grant_found_s;
   logic [IDX_W-1:0]    grant_idx_s;
   logic [ADDR_W-1:0]   grant_addr_s;
   logic                hit_s;
   logic [IDX_W-1:0]    rr_next_s;
   logic                wait_expired_s;

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (IDX_W'(k) == idx) v[k] = 1'b1;
         else                  v[k] = 1'b0;
      end
      return v;
   endfunction

   // Round-robin pick: first active request at or above rr_ptr, wrapping.
   always_comb begin
      logic [IDX_W:0] cand_v;
      cand_v        = '0;
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand_v = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
         if (cand_v >= (IDX_W+1)'(N_REQ)) cand_v = cand_v - (IDX_W+1)'(N_REQ);
         else                             cand_v = cand_v;
         if (!grant_found_s && req[cand_v[IDX_W-1:0]]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_v[IDX_W-1:0];
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // Cache lookup and auxiliary decode for the candidate grant.
   always_comb begin
      grant_addr_s   = req_addr[grant_idx_s*ADDR_W +: ADDR_W];
      hit_s          = cache_valid_r[grant_idx_s] && (cache_tag_r[grant_idx_s] == grant_addr_s);
      wait_expired_s = (cnt_r == CNT_W'(TIMEOUT - 1));
      if (grant_idx_s == IDX_W'(N_REQ - 1)) rr_next_s = '0;
      else                                  rr_next_s = grant_idx_s + IDX_W'(1);
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!inhibit && grant_found_s) state_s = hit_s ? ST_HIT : ST_ISSUE;
            else                           state_s = ST_IDLE;
         end
         ST_HIT:     state_s = ST_IDLE;
         ST_ISSUE:   state_s = ST_WAIT;
         ST_WAIT: begin
            if (mem_ack)             state_s = ST_DELIVER;
            else if (wait_expired_s) state_s = ST_IDLE;
            else                     state_s = ST_WAIT;
         end
         ST_DELIVER: state_s = ST_IDLE;
         default:    state_s = ST_IDLE;
      endcase
   end

   // State, grant bookkeeping, cache and registered outputs.
   always_ff @(posedge clk_sys) begin
      if (!nRESET) begin
         state_r        <= ST_IDLE;
         rr_ptr_r       <= '0;
         grant_r        <= '0;
         addr_r         <= '0;
         cnt_r          <= '0;
         inhibit_seen_r <= 1'b0;
         cache_valid_r  <= '0;
         for (int k = 0; k < N_REQ; k++) begin
            cache_tag_r[k]  <= '0;
            cache_data_r[k] <= 32'h0000_0000;
         end
         rdy_r          <= '0;
         dout_r         <= 32'h0000_0000;
         mem_req_r      <= 1'b0;
         mem_addr_r     <= '0;
         timeout_err_r  <= 1'b0;
      end else begin
         state_r   <= state_s;
         rdy_r     <= '0;
         mem_req_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (state_s != ST_IDLE) begin
                  grant_r        <= grant_idx_s;
                  addr_r         <= grant_addr_s;
                  rr_ptr_r       <= rr_next_s;
                  inhibit_seen_r <= 1'b0;
                  if (state_s == ST_HIT) begin
                     rdy_r  <= onehot(grant_idx_s);
                     dout_r <= cache_data_r[grant_idx_s];
                  end else begin
                     mem_req_r  <= 1'b1;
                     mem_addr_r <= grant_addr_s;
                  end
               end
            end
            ST_ISSUE: cnt_r <= '0;
            ST_WAIT: begin
               if (mem_ack) begin
                  rdy_r  <= onehot(grant_r);
                  dout_r <= mem_dout;
               end else if (wait_expired_s) begin
                  timeout_err_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_DELIVER: begin
               if (!inhibit_seen_r && !inhibit) begin
                  cache_valid_r[grant_r] <= 1'b1;
                  cache_tag_r[grant_r]   <= addr_r;
                  cache_data_r[grant_r]  <= dout_r;
               end
            end
            default: ;
         endcase
         // Inhibit overrides any fill made in the same cycle.
         if (inhibit) begin
            inhibit_seen_r <= 1'b1;
            cache_valid_r  <= '0;
         end
      end
   end

   assign rdy         = rdy_r;
   assign dout        = dout_r;
   assign mem_req     = mem_req_r;
   assign mem_addr    = mem_addr_r;
   assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_snd_rom_arbiter.sv
// Self-checking bench for snd_rom_arbiter: directed scenarios plus a randomized
// request stream checked against a round-robin / per-requester cache model.
module tb_snd_rom_arbiter;

   localparam int N_REQ   = 3;
   localparam int ADDR_W  = 18;
   localparam int TIMEOUT = 255;

   logic                    clk_sys = 1'b0;
   logic                    nRESET;
   logic                    inhibit;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ-1:0]        rdy;
   logic [31:0]             dout;
   logic                    mem_req;
   logic [ADDR_W-1:0]       mem_addr;
   logic                    mem_ack;
   logic [31:0]             mem_dout;
   logic                    timeout_err;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   int              ack_delay  = 3;
   bit              ack_enable = 1'b1;
   int              resp_cnt   = 0;
   logic [17:0]     resp_addr  = 18'h0;
   int              last_req_cyc = 0;

   snd_rom_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_sys(clk_sys), .nRESET(nRESET), .inhibit(inhibit), .req(req), .req_addr(req_addr),
      .rdy(rdy), .dout(dout), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_dout(mem_dout), .timeout_err(timeout_err)
   );

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   function automatic logic [31:0] mem_func(input logic [17:0] a);
      if (a == 18'h00100) return 32'hDEADBEEF;
      return ({14'h0, a} * 32'h9E3779B1) ^ 32'hA5A50F0F;
   endfunction

   // SDRAM stand-in: one-cycle ack ack_delay cycles after mem_req.
   always @(negedge clk_sys) begin
      mem_ack = 1'b0;
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) begin
            mem_ack  = 1'b1;
            mem_dout = mem_func(resp_addr);
         end
      end
      if (mem_req === 1'b1 && ack_enable) begin
         resp_cnt     = ack_delay;
         resp_addr    = mem_addr;
         last_req_cyc = cyc;
      end
   end

   task automatic set_addr(input int i, input logic [17:0] a);
      req_addr[i*ADDR_W +: ADDR_W] = a;
   endtask

   task automatic do_reset();
      @(negedge clk_sys);
      nRESET = 1'b0; req = '0; inhibit = 1'b0;
      repeat (2) @(negedge clk_sys);
      nRESET = 1'b1;
   endtask

   task automatic wait_rdy(input int budget, output logic [2:0] r, output logic [31:0] d,
                           output int nreq, output logic [17:0] ma, output int rc, output bit got);
      got = 1'b0; r = '0; d = '0; nreq = 0; ma = '0; rc = 0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk_sys);
         if (mem_req === 1'b1) begin nreq++; ma = mem_addr; end
         if (rdy !== 3'b000) begin got = 1'b1; r = rdy; d = dout; rc = cyc; end
      end
   endtask

   task automatic wait_mem_req(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk_sys);
         if (mem_req === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (rdy !== 3'b000) $display("FAIL reset_rdy: got=%b expected=000", rdy); else passed++;
      total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got=%b expected=0", mem_req); else passed++;
      total++; if (mem_addr !== 18'h0) $display("FAIL reset_mem_addr: got=%h expected=0", mem_addr); else passed++;
      total++; if (dout !== 32'h0) $display("FAIL reset_dout: got=%h expected=0", dout); else passed++;
      total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got=%b expected=0", timeout_err); else passed++;
   endtask

   task automatic test_miss();
      logic [2:0] r; logic [31:0] d; int nreq; logic [17:0] ma; int rc; bit got;
      ack_delay = 5;
      set_addr(1, 18'h00100);
      req = 3'b010;
      wait_rdy(50, r, d, nreq, ma, rc, got);
      req = 3'b000;
      total++; if (r !== 3'b010) $display("FAIL miss_rdy: got=%b expected=010", r); else passed++;
      total++; if (d !== 32'hDEADBEEF) $display("FAIL miss_dout: got=%h expected=deadbeef", d); else passed++;
      total++; if (nreq !== 1) $display("FAIL miss_mem_req_count: got=%0d expected=1", nreq); else passed++;
      total++; if (ma !== 18'h00100) $display("FAIL miss_mem_addr: got=%h expected=00100", ma); else passed++;
      total++; if (rc !== last_req_cyc + 6) $display("FAIL miss_latency: got=%0d expected=%0d", rc, last_req_cyc + 6); else passed++;
   endtask

   task automatic test_hit();
      logic [2:0] r; logic [31:0] d; int nreq; logic [17:0] ma; int rc; bit got; int t0;
      @(negedge clk_sys);
      t0 = cyc;
      req = 3'b010;
      wait_rdy(20, r, d, nreq, ma, rc, got);
      req = 3'b000;
      total++; if (r !== 3'b010) $display("FAIL hit_rdy: got=%b expected=010", r); else passed++;
      total++; if (d !== 32'hDEADBEEF) $display("FAIL hit_dout: got=%h expected=deadbeef", d); else passed++;
      total++; if (nreq !== 0) $display("FAIL hit_no_mem_req: got=%0d expected=0", nreq); else passed++;
      total++; if (rc !== t0 + 1) $display("FAIL hit_latency: got=%0d expected=%0d", rc, t0 + 1); else passed++;
   endtask

   task automatic test_inhibit();
      logic [2:0] r; logic [31:0] d; int nreq; logic [17:0] ma; int rc; bit got; bit seen;
      @(negedge clk_sys);
      inhibit = 1'b1;
      req = 3'b010;
      wait_rdy(5, r, d, nreq, ma, rc, got);
      total++; if (got !== 1'b0 || nreq !== 0) $display("FAIL inhibit_no_grant: rdy_seen=%b mem_reqs=%0d expected=0/0", got, nreq); else passed++;
      inhibit = 1'b0;
      wait_rdy(50, r, d, nreq, ma, rc, got);
      req = 3'b000;
      total++; if (nreq !== 1) $display("FAIL inhibit_cache_cleared: mem_reqs=%0d expected=1", nreq); else passed++;
      total++; if (r !== 3'b010 || d !== 32'hDEADBEEF) $display("FAIL inhibit_refetch: rdy=%b dout=%h expected=010/deadbeef", r, d); else passed++;
      // Inhibit during an in-flight access: completes, but does not fill.
      ack_delay = 6;
      set_addr(0, 18'h02ABC);
      req = 3'b001;
      wait_mem_req(seen);
      @(negedge clk_sys); inhibit = 1'b1;
      @(negedge clk_sys); inhibit = 1'b0;
      wait_rdy(30, r, d, nreq, ma, rc, got);
      req = 3'b000;
      total++; if (r !== 3'b001 || d !== mem_func(18'h02ABC)) $display("FAIL inflight_deliver: rdy=%b dout=%h expected=001/%h", r, d, mem_func(18'h02ABC)); else passed++;
      @(negedge clk_sys);
      req = 3'b001;
      wait_rdy(30, r, d, nreq, ma, rc, got);
      req = 3'b000;
      total++; if (nreq !== 1) $display("FAIL inflight_no_fill: mem_reqs=%0d expected=1", nreq); else passed++;
   endtask

   task automatic test_round_robin();
      logic [2:0] r; logic [31:0] d; int nreq; logic [17:0] ma; int rc; bit got;
      do_reset();
      ack_delay = 2;
      for (int round = 0; round < 2; round++) begin
         for (int i = 0; i < N_REQ; i++) set_addr(i, 18'h01000 + 18'(round * 16 + i));
         req = 3'b111;
         for (int k = 0; k < N_REQ; k++) begin
            wait_rdy(40, r, d, nreq, ma, rc, got);
            req = req & ~r;
            total++; if (r !== (3'b001 << k)) $display("FAIL rr_order: round=%0d slot=%0d got=%b expected=%b", round, k, r, 3'b001 << k); else passed++;
            total++; if (d !== mem_func(18'h01000 + 18'(round * 16 + k))) $display("FAIL rr_dout: round=%0d slot=%0d got=%h", round, k, d); else passed++;
         end
      end
      req = 3'b000;
   endtask

   task automatic test_timeout();
      logic [2:0] r; logic [31:0] d; int nreq; logic [17:0] ma; int rc; bit got; bit seen;
      int mcyc; int errcyc; bit saw_rdy;
      ack_enable = 1'b0;
      set_addr(2, 18'h03F00);
      req = 3'b100;
      wait_mem_req(seen);
      mcyc = cyc; errcyc = -1; saw_rdy = 1'b0;
      for (int i = 0; i < 300 && errcyc < 0; i++) begin
         @(negedge clk_sys);
         if (rdy !== 3'b000) saw_rdy = 1'b1;
         if (timeout_err === 1'b1) begin errcyc = cyc; req = 3'b000; end
      end
      req = 3'b000;
      total++; if (saw_rdy !== 1'b0) $display("FAIL timeout_no_rdy: got=%b expected=0", saw_rdy); else passed++;
      total++; if (errcyc - mcyc !== TIMEOUT + 1) $display("FAIL timeout_latency: got=%0d expected=%0d", errcyc - mcyc, TIMEOUT + 1); else passed++;
      repeat (10) @(negedge clk_sys);
      total++; if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got=%b expected=1", timeout_err); else passed++;
      ack_enable = 1'b1;
      set_addr(0, 18'h00777);
      req = 3'b001;
      wait_rdy(40, r, d, nreq, ma, rc, got);
      req = 3'b000;
      total++; if (r !== 3'b001 || d !== mem_func(18'h00777)) $display("FAIL timeout_recover: rdy=%b dout=%h expected=001/%h", r, d, mem_func(18'h00777)); else passed++;
      total++; if (timeout_err !== 1'b1) $display("FAIL timeout_sticky_after: got=%b expected=1", timeout_err); else passed++;
   endtask

   task automatic test_reset_mid_access();
      logic [2:0] r; logic [31:0] d; int nreq; logic [17:0] ma; int rc; bit got; bit seen;
      ack_delay = 8;
      set_addr(0, 18'h00500);
      req = 3'b001;
      wait_rdy(40, r, d, nreq, ma, rc, got);
      req = 3'b000;
      @(negedge clk_sys);
      set_addr(0, 18'h00600);
      req = 3'b001;
      wait_mem_req(seen);
      repeat (2) @(negedge clk_sys);
      nRESET = 1'b0; req = 3'b000;
      @(negedge clk_sys);
      nRESET = 1'b1;
      wait_rdy(20, r, d, nreq, ma, rc, got);
      total++; if (got !== 1'b0 || nreq !== 0) $display("FAIL reset_mid_late_ack: rdy_seen=%b mem_reqs=%0d expected=0/0", got, nreq); else passed++;
      total++; if (timeout_err !== 1'b0) $display("FAIL reset_mid_timeout_err: got=%b expected=0", timeout_err); else passed++;
      set_addr(0, 18'h00500);
      req = 3'b001;
      wait_rdy(40, r, d, nreq, ma, rc, got);
      req = 3'b000;
      total++; if (nreq !== 1) $display("FAIL reset_mid_cache_invalid: mem_reqs=%0d expected=1", nreq); else passed++;
      total++; if (r !== 3'b001 || d !== mem_func(18'h00500)) $display("FAIL reset_mid_serve: rdy=%b dout=%h", r, d); else passed++;
   endtask

   task automatic test_random();
      logic [2:0] r; logic [31:0] d; int nreq; logic [17:0] ma; int rc; bit got;
      bit mv [N_REQ]; logic [17:0] mtag [N_REQ]; int mrr; int g; bit hit; logic [17:0] ga;
      do_reset();
      mrr = 0;
      for (int i = 0; i < N_REQ; i++) begin
         mv[i] = 1'b0; mtag[i] = 18'h0;
         set_addr(i, 18'h00A00 + 18'($urandom_range(0, 3)));
      end
      req = 3'($urandom_range(1, 7));
      for (int t = 0; t < 60; t++) begin
         g = -1;
         for (int k = 0; k < N_REQ; k++)
            if (g < 0 && req[(mrr + k) % N_REQ]) g = (mrr + k) % N_REQ;
         ga  = req_addr[g*ADDR_W +: ADDR_W];
         hit = mv[g] && (mtag[g] == ga);
         ack_delay = $urandom_range(1, 6);
         wait_rdy(60, r, d, nreq, ma, rc, got);
         total++; if (r !== (3'b001 << g)) $display("FAIL rand_grant: txn=%0d got=%b expected=%b", t, r, 3'b001 << g); else passed++;
         total++; if (d !== mem_func(ga)) $display("FAIL rand_dout: txn=%0d got=%h expected=%h", t, d, mem_func(ga)); else passed++;
         total++; if (nreq !== (hit ? 0 : 1)) $display("FAIL rand_hit_miss: txn=%0d mem_reqs=%0d expected=%0d", t, nreq, hit ? 0 : 1); else passed++;
         mrr = (g + 1) % N_REQ;
         mv[g] = 1'b1; mtag[g] = ga;
         for (int i = 0; i < N_REQ; i++) begin
            if (i == g || req[i] == 1'b0) begin
               req[i] = ($urandom_range(0, 3) != 0);
               if (req[i] && $urandom_range(0, 1) == 1) set_addr(i, 18'h00A00 + 18'($urandom_range(0, 3)));
            end
         end
         if (req == 3'b000) req[$urandom_range(0, 2)] = 1'b1;
      end
      req = 3'b000;
   endtask

   initial begin
      nRESET = 1'b0; inhibit = 1'b0; req = '0; req_addr = '0; mem_ack = 1'b0; mem_dout = 32'h0;
      test_reset();
      test_miss();
      test_hit();
      test_inhibit();
      test_round_robin();
      test_timeout();
      test_reset_mid_access();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", passed, total);
      $fatal(1);
   end

endmodule
